waitstate_ctrl: RTL and testbench
=================================

Name: waitstate_ctrl

Overview:
- Parametrised bus wait-state generator; successor to the fixed-count pause generator in the CPU sim memory system.
- Decodes each accepted CPU bus access into a GBA memory region and computes the wait count from a software-programmable WAITCNT register.
- Distinguishes sequential from non-sequential access, and adds the second-halfword penalty for 32-bit accesses on 16-bit buses.
- Drives PAUSE to the core and to all memories.

Parameters:
CNT_W, 5, width of the wait-cycle down-counter; must hold 17 (8+8+1)
WAITCNT_ADDR, 32'h0400_0204, byte address of the WAITCNT I/O register
WAITCNT_RESET, 16'h0000, WAITCNT value after reset
EWRAM_WAIT, 2, fixed wait count for region 0x2 (EWRAM), N and S

Ports:
clk  in  1  system clock
rst_n  in  1  reset; active low; synchronous
addr  in  32  CPU bus address
size  in  2  byte/half/word encoding; MEM_SIZE_* constants
write  in  1  access is a write
valid  in  1  CPU presents an access this cycle
wdata  in  32  write data; valid one cycle after addr/write
pause  out  1  stall to core and memories
seq  out  1  last accepted access was sequential
waitcnt  out  16  current WAITCNT value; bit 15 always reads 0
wait_left  out  CNT_W  remaining pause cycles

Behaviour:
- Reset is synchronous and active-low, with one clock (clk, rst_n). Reset values: pause=0, seq=0, wait_left=0, waitcnt=WAITCNT_RESET with bit 15 cleared, and prev-access state invalid.
- Accept rule: an access is accepted at edge T when valid && ~pause. Accesses presented while pause=1 are ignored; the CPU holds them.
- Latency:
  - The counter loads W at edge T.
  - pause is high for cycles T+1 .. T+W and low again at T+W+1.
  - W=0 leaves pause low.
- Region decode uses addr[27:24]:
  - 0x0 BIOS, 0x3 IWRAM, 0x4 IO, 0x5 palette, 0x6 VRAM, 0x7 OAM: W=0.
  - 0x2 EWRAM: EWRAM_WAIT.
  - 0x8/0x9 WS0, 0xA/0xB WS1, 0xC/0xD WS2.
  - 0xE/0xF SRAM.
  - Undefined regions: W=0.
- WAITCNT field map:
  - [1:0] SRAM wait {4,3,2,8}.
  - [3:2] WS0 N {4,3,2,8}; [4] WS0 S {2,1}.
  - [6:5] WS1 N {4,3,2,8}; [7] WS1 S {4,1}.
  - [9:8] WS2 N {4,3,2,8}; [10] WS2 S {8,1}.
  - [14:11] stored, no effect.
- Sequential detection:
  - Requires a ROM region (WS0–2), the same region as the previous accepted access, and addr == prev_addr + bytes(prev_size).
  - Forced non-sequential when addr[16:0]==0 (128 KiB boundary), after any cycle with valid=0 at pause=0, and after a WAITCNT write.
  - seq updates at accept.
- Wait arithmetic:
  - first = seq ? S : N.
  - A word access to a 16-bit region (EWRAM, ROM) adds S+1, where S is EWRAM_WAIT for EWRAM.
  - SRAM uses a single SRAM wait regardless of size.
  - The sum is saturated at 2^CNT_W−1.
- WAITCNT write:
  - Triggered by an accepted write with addr[31:2]==WAITCNT_ADDR[31:2], size half (addr[1]=0) or word.
  - Sets a pending flag. At the next edge with pause=0, waitcnt[14:0] <= wdata[14:0] and the flag clears.
  - The new value applies to accesses accepted from the edge after the capture.
  - Byte writes: lane addr[0] updates that byte only; bit 15 is never written.
- Simultaneous: if a new access is accepted on the same edge as a WAITCNT capture, that access uses the old waitcnt.
- Reset mid-pause: pause and wait_left are 0 at the edge after rst_n=0 is sampled; the pending write is dropped.

Decomposition:
- Shared package gba_mem_pkg holds:
  - region enum (BIOS, EWRAM, IWRAM, IO, PAL, VRAM, OAM, WS0, WS1, WS2, SRAM, NONE);
  - MEM_SIZE_* constants;
  - N-wait table {4,3,2,8};
  - WAITCNT field offsets.
- One combinational sub-module, ws_lookup: (region, size, seq, waitcnt) -> W.
- Top level holds the accept logic, prev-access registers, WAITCNT pending/capture, and the down-counter.

Test Plan:
- Reset, waitcnt=0. Half read 0x0800_0000 -> pause 4 cycles, seq=0. Then half 0x0800_0002 -> pause 2, seq=1.
- Word read 0x0800_0000 (non-seq, waitcnt=0) -> pause 7 (4+2+1). Word read 0x0200_0000 -> pause 5. Word read 0x0300_0000 -> pause stays 0.
- Word write 0x0400_0204, wdata 0x0000_4317 next cycle -> waitcnt=0x4317. Then half 0x0800_0000 -> 3; seq half 0x0800_0002 -> 1; half 0x0C00_0000 -> 8; byte 0x0E00_0000 -> 8.
- Half 0x0801_FFFE then half 0x0802_0000 (contiguous) -> second access non-seq, pause 4.
- Write 0xFFFF to 0x0400_0204 -> waitcnt reads 0x7FFF. Half read 0x0800_0000 accepted on the capture edge -> uses old waitcnt.
- Assert rst_n=0 at wait_left=5 -> pause=0, wait_left=0, waitcnt=WAITCNT_RESET after that edge. The next accepted half 0x0800_0002 after the first is non-seq.

Source files
------------

// File: rtl/gba_mem_pkg.sv
// Shared GBA memory-map definitions: region decode, access sizes, WAITCNT field layout.
package gba_mem_pkg;

  typedef enum logic [3:0] {
    REG_BIOS, REG_EWRAM, REG_IWRAM, REG_IO, REG_PAL, REG_VRAM,
    REG_OAM, REG_WS0, REG_WS1, REG_WS2, REG_SRAM, REG_NONE
  } region_e;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  localparam int WC_SRAM = 0;
  localparam int WC_WS0N = 2;
  localparam int WC_WS0S = 4;
  localparam int WC_WS1N = 5;
  localparam int WC_WS1S = 7;
  localparam int WC_WS2N = 8;
  localparam int WC_WS2S = 10;

  // 2-bit N-wait field -> cycles {4,3,2,8}
  function automatic logic [3:0] nwait(input logic [1:0] f);
    case (f)
      2'd0:    nwait = 4'd4;
      2'd1:    nwait = 4'd3;
      2'd2:    nwait = 4'd2;
      default: nwait = 4'd8;
    endcase
  endfunction

  function automatic region_e decode_region(input logic [3:0] a);
    case (a)
      4'h0:        decode_region = REG_BIOS;
      4'h2:        decode_region = REG_EWRAM;
      4'h3:        decode_region = REG_IWRAM;
      4'h4:        decode_region = REG_IO;
      4'h5:        decode_region = REG_PAL;
      4'h6:        decode_region = REG_VRAM;
      4'h7:        decode_region = REG_OAM;
      4'h8, 4'h9:  decode_region = REG_WS0;
      4'hA, 4'hB:  decode_region = REG_WS1;
      4'hC, 4'hD:  decode_region = REG_WS2;
      4'hE, 4'hF:  decode_region = REG_SRAM;
      default:     decode_region = REG_NONE;
    endcase
  endfunction

  function automatic logic is_rom(input region_e r);
    is_rom = (r == REG_WS0) || (r == REG_WS1) || (r == REG_WS2);
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      MEM_SIZE_BYTE: size_bytes = 3'd1;
      MEM_SIZE_HALF: size_bytes = 3'd2;
      default:       size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/ws_lookup.sv
// Combinational wait-count lookup: (region, size, seq, WAITCNT) -> wait cycles, saturated.
module ws_lookup
  import gba_mem_pkg::*;
#(
  parameter int CNT_W      = 5,
  parameter int EWRAM_WAIT = 2
) (
  input  logic [3:0]       region_i,
  input  logic [1:0]       size_i,
  input  logic             seq_i,
  input  logic [10:0]      waitcnt_i,
  output logic [CNT_W-1:0] wait_o
);

  localparam logic [7:0] SAT = 8'((1 << CNT_W) - 1);

  logic [7:0] n_w, s_w, sum;
  logic       bus16;

  always_comb begin
    n_w   = '0;
    s_w   = '0;
    bus16 = 1'b0;
    case (region_e'(region_i))
      REG_EWRAM: begin
        n_w = 8'(EWRAM_WAIT); s_w = 8'(EWRAM_WAIT); bus16 = 1'b1;
      end
      REG_WS0: begin
        n_w = {4'd0, nwait(waitcnt_i[WC_WS0N+:2])};
        s_w = waitcnt_i[WC_WS0S] ? 8'd1 : 8'd2; bus16 = 1'b1;
      end
      REG_WS1: begin
        n_w = {4'd0, nwait(waitcnt_i[WC_WS1N+:2])};
        s_w = waitcnt_i[WC_WS1S] ? 8'd1 : 8'd4; bus16 = 1'b1;
      end
      REG_WS2: begin
        n_w = {4'd0, nwait(waitcnt_i[WC_WS2N+:2])};
        s_w = waitcnt_i[WC_WS2S] ? 8'd1 : 8'd8; bus16 = 1'b1;
      end
      // SRAM is 8-bit: one wait per access whatever the size
      REG_SRAM: begin
        n_w = {4'd0, nwait(waitcnt_i[WC_SRAM+:2])};
        s_w = n_w;
      end
      default: ;
    endcase
    sum = seq_i ? s_w : n_w;
    if (bus16 && size_i == MEM_SIZE_WORD) sum = sum + s_w + 8'd1;
  end

  assign wait_o = (sum > SAT) ? SAT[CNT_W-1:0] : sum[CNT_W-1:0];

endmodule

// File: rtl/waitstate_ctrl.sv
// Bus wait-state generator: accepts CPU accesses, tracks sequentiality, owns WAITCNT and PAUSE.
module waitstate_ctrl
  import gba_mem_pkg::*;
#(
  parameter int          CNT_W         = 5,
  parameter logic [31:0] WAITCNT_ADDR  = 32'h0400_0204,
  parameter logic [15:0] WAITCNT_RESET = 16'h0000,
  parameter int          EWRAM_WAIT    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [1:0]       size,
  input  logic             write,
  input  logic             valid,
  input  logic [31:0]      wdata,
  output logic             pause,
  output logic             seq,
  output logic [15:0]      waitcnt,
  output logic [CNT_W-1:0] wait_left
);

  logic [CNT_W-1:0] cnt_q, cnt_d, w_c;
  logic             seq_q, seq_d;
  logic [14:0]      wc_q, wc_d;
  logic             pend_q, pend_d;
  logic [1:0]       pmask_q, pmask_d;
  logic             pv_q, pv_d;
  logic [31:0]      paddr_q, paddr_d;
  logic [1:0]       psize_q, psize_d;
  region_e          preg_q, preg_d;

  region_e reg_c;
  logic    accept, seq_hit, wc_hit;
  logic    unused_wdata;

  assign pause     = |cnt_q;
  assign seq       = seq_q;
  assign wait_left = cnt_q;
  assign waitcnt   = {1'b0, wc_q};
  assign unused_wdata = ^wdata[31:15];

  assign accept  = valid & ~pause;
  assign reg_c   = decode_region(addr[27:24]);
  // Contiguous ROM stream in the same wait-state window, not crossing a 128 KiB page
  assign seq_hit = pv_q && is_rom(reg_c) && (reg_c == preg_q) &&
                   (addr == paddr_q + 32'(size_bytes(psize_q))) && (addr[16:0] != 17'd0);
  assign wc_hit  = write && (addr[31:2] == WAITCNT_ADDR[31:2]) &&
                   ((size == MEM_SIZE_WORD) || ~addr[1]);

  ws_lookup #(.CNT_W(CNT_W), .EWRAM_WAIT(EWRAM_WAIT)) u_lookup (
    .region_i  (reg_c),
    .size_i    (size),
    .seq_i     (seq_hit),
    .waitcnt_i (wc_q[10:0]),
    .wait_o    (w_c)
  );

  always_comb begin
    cnt_d   = pause ? cnt_q - CNT_W'(1) : cnt_q;
    seq_d   = seq_q;
    wc_d    = wc_q;
    pend_d  = pend_q;
    pmask_d = pmask_q;
    pv_d    = pv_q;
    paddr_d = paddr_q;
    psize_d = psize_q;
    preg_d  = preg_q;

    // wdata arrives the cycle after the write; a same-edge access still sees wc_q
    if (pend_q && !pause) begin
      if (pmask_q[0]) wc_d[7:0]  = wdata[7:0];
      if (pmask_q[1]) wc_d[14:8] = wdata[14:8];
      pend_d = 1'b0;
    end

    if (accept) begin
      cnt_d   = w_c;
      seq_d   = seq_hit;
      pv_d    = ~wc_hit;
      paddr_d = addr;
      psize_d = size;
      preg_d  = reg_c;
      if (wc_hit) begin
        pend_d  = 1'b1;
        pmask_d = (size == MEM_SIZE_BYTE) ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
      end
    end else if (!valid && !pause) begin
      pv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      seq_q   <= 1'b0;
      wc_q    <= WAITCNT_RESET[14:0];
      pend_q  <= 1'b0;
      pmask_q <= 2'b00;
      pv_q    <= 1'b0;
      paddr_q <= '0;
      psize_q <= MEM_SIZE_BYTE;
      preg_q  <= REG_NONE;
    end else begin
      cnt_q   <= cnt_d;
      seq_q   <= seq_d;
      wc_q    <= wc_d;
      pend_q  <= pend_d;
      pmask_q <= pmask_d;
      pv_q    <= pv_d;
      paddr_q <= paddr_d;
      psize_q <= psize_d;
      preg_q  <= preg_d;
    end
  end

endmodule

// File: tb/tb_waitstate_ctrl.sv
// Directed + random bench for waitstate_ctrl against a per-access arithmetic reference model.
module tb_waitstate_ctrl;
  localparam int CNT_W = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [1:0] size = '0;
  logic write = 1'b0, valid = 1'b0;
  logic pause, seq;
  logic [15:0] waitcnt;
  logic [CNT_W-1:0] wait_left;

  int vectors = 0, miscompares = 0;

  // reference model state
  logic [15:0] m_wc = '0;
  bit          m_prev_ok = 0;
  logic [31:0] m_prev_addr = '0;
  logic [1:0]  m_prev_sz = '0;
  bit          m_pend = 0;
  logic [31:0] m_pdata = '0;
  logic [1:0]  m_pmask = '0;

  waitstate_ctrl #(.CNT_W(CNT_W), .WAITCNT_ADDR(32'h0400_0204),
                   .WAITCNT_RESET(16'h0000), .EWRAM_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .size(size), .write(write),
    .valid(valid), .wdata(wdata), .pause(pause), .seq(seq),
    .waitcnt(waitcnt), .wait_left(wait_left));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nw(input logic [1:0] f);
    return (f == 0) ? 4 : (f == 1) ? 3 : (f == 2) ? 2 : 8;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 0) ? 1 : (s == 1) ? 2 : 4;
  endfunction

  function automatic int model_w(input logic [31:0] a, input logic [1:0] sz, input bit s,
                                 input logic [15:0] wc);
    int top, n, sw, w;
    bit b16;
    top = int'(a[27:24]);
    n = 0; sw = 0; b16 = 0;
    if (top == 2) begin n = 2; sw = 2; b16 = 1; end
    else if (top == 8 || top == 9) begin n = nw(wc[3:2]); sw = wc[4] ? 1 : 2; b16 = 1; end
    else if (top == 10 || top == 11) begin n = nw(wc[6:5]); sw = wc[7] ? 1 : 4; b16 = 1; end
    else if (top == 12 || top == 13) begin n = nw(wc[9:8]); sw = wc[10] ? 1 : 8; b16 = 1; end
    else if (top >= 14) return nw(wc[1:0]);
    else return 0;
    w = s ? sw : n;
    if (b16 && sz == 2) w = w + sw + 1;
    return (w > 31) ? 31 : w;
  endfunction

  function automatic void apply_capture();
    if (m_pmask[0]) m_wc[7:0]  = m_pdata[7:0];
    if (m_pmask[1]) m_wc[14:8] = m_pdata[14:8];
    m_pend = 0;
  endfunction

  function automatic void model_reset();
    m_wc = '0; m_prev_ok = 0; m_pend = 0;
  endfunction

  // entered at a negedge with pause low; returns at the first negedge with pause low again
  task automatic access(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                        input logic [31:0] wd, output int got_w);
    int top, ptop, ew, n;
    bit es, hit;
    top  = int'(a[27:24]);
    ptop = int'(m_prev_addr[27:24]);
    es = m_prev_ok && top >= 8 && top <= 13 && (top / 2) == (ptop / 2) &&
         a == m_prev_addr + 32'(nbytes(m_prev_sz)) && a[16:0] != 0;
    ew  = model_w(a, sz, es, m_wc);
    hit = wr && a[31:2] == 30'h0100_0081 && (sz == 2 || !a[1]);
    addr = a; size = sz; write = wr; valid = 1'b1;
    @(posedge clk); #1;
    chk("seq", 32'(seq), 32'(es));
    chk("wait_left", 32'(wait_left), 32'(ew));
    wdata = wd;
    if (m_pend) apply_capture();
    m_prev_ok = !hit; m_prev_addr = a; m_prev_sz = sz;
    if (hit) begin
      m_pend = 1; m_pdata = wd;
      m_pmask = (sz == 0) ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    end
    n = 0;
    @(negedge clk);
    while (pause && n < 64) begin n++; @(negedge clk); end
    chk("pause_len", 32'(n), 32'(ew));
    got_w = n;
  endtask

  task automatic idle();
    valid = 1'b0; write = 1'b0;
    @(posedge clk);
    if (m_pend) apply_capture();
    m_prev_ok = 0;
    @(negedge clk);
  endtask

  initial begin
    int w, k;
    logic [3:0] t;
    logic [1:0] sz;
    logic [31:0] a;
    int r;

    // reset
    rst_n = 1'b0; valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pause", 32'(pause), 0);
    chk("rst_seq", 32'(seq), 0);
    chk("rst_wait_left", 32'(wait_left), 0);
    chk("rst_waitcnt", 32'(waitcnt), 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;

    access(32'h0800_0000, 2'd1, 1'b0, 0, w); chk("tp_half_n", 32'(w), 4);
    access(32'h0800_0002, 2'd1, 1'b0, 0, w); chk("tp_half_s", 32'(w), 2);
    chk("tp_seq1", 32'(seq), 1);
    access(32'h0800_0000, 2'd2, 1'b0, 0, w); chk("tp_word_ws0", 32'(w), 7);
    access(32'h0200_0000, 2'd2, 1'b0, 0, w); chk("tp_word_ewram", 32'(w), 5);
    access(32'h0300_0000, 2'd2, 1'b0, 0, w); chk("tp_word_iwram", 32'(w), 0);
    access(32'h0801_FFFE, 2'd1, 1'b0, 0, w); chk("tp_pre_bnd", 32'(w), 4);
    access(32'h0802_0000, 2'd1, 1'b0, 0, w); chk("tp_bnd", 32'(w), 4);
    chk("tp_bnd_seq", 32'(seq), 0);

    access(32'h0400_0204, 2'd2, 1'b1, 32'h0000_4317, w);
    idle();
    chk("tp_wc4317", 32'(waitcnt), 32'h4317);
    access(32'h0800_0000, 2'd1, 1'b0, 0, w); chk("tp_ws0n", 32'(w), 3);
    access(32'h0800_0002, 2'd1, 1'b0, 0, w); chk("tp_ws0s", 32'(w), 1);
    access(32'h0C00_0000, 2'd1, 1'b0, 0, w); chk("tp_ws2n", 32'(w), 8);
    access(32'h0E00_0000, 2'd0, 1'b0, 0, w); chk("tp_sram", 32'(w), 8);

    // access on the capture edge still sees the old WAITCNT
    access(32'h0400_0204, 2'd2, 1'b1, 32'h0000_FFFF, w);
    access(32'h0800_0000, 2'd1, 1'b0, 0, w); chk("tp_old_wc", 32'(w), 3);
    chk("tp_wc7fff", 32'(waitcnt), 32'h7FFF);

    access(32'h0400_0205, 2'd0, 1'b1, 32'h0000_1200, w);
    idle();
    chk("tp_byte_lane1", 32'(waitcnt), 32'h12FF);

    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) begin
        idle();
      end else if (r < 18) begin
        sz = 2'($urandom_range(0, 2));
        a = 32'h0400_0204;
        if (sz == 2'd0) a[0] = 1'($urandom_range(0, 1));
        access(a, sz, 1'b1, $urandom, w);
      end else begin
        t  = 4'($urandom_range(0, 15));
        sz = 2'($urandom_range(0, 2));
        if (r < 50 && m_prev_ok) a = m_prev_addr + 32'(nbytes(m_prev_sz));
        else begin
          a = {4'h0, t, 24'($urandom)};
          if ($urandom_range(0, 9) == 0) a[16:0] = '0;
        end
        access(a, sz, 1'($urandom_range(0, 3) == 0), $urandom, w);
      end
      chk("rnd_waitcnt", 32'(waitcnt), 32'(m_wc));
    end

    // reset in the middle of a pause
    access(32'h0400_0204, 2'd2, 1'b1, 32'h0000_000C, w);
    idle();
    chk("wc_000c", 32'(waitcnt), 32'h000C);
    addr = 32'h0800_0000; size = 2'd1; write = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    chk("mid_load", 32'(wait_left), 8);
    k = 0;
    while (wait_left != 5 && k < 20) begin @(negedge clk); k++; end
    chk("mid_at5", 32'(wait_left), 5);
    rst_n = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_pause", 32'(pause), 0);
    chk("mid_rst_wait_left", 32'(wait_left), 0);
    chk("mid_rst_waitcnt", 32'(waitcnt), 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    access(32'h0800_0002, 2'd1, 1'b0, 0, w); chk("post_rst_nseq", 32'(w), 4);
    chk("post_rst_seq", 32'(seq), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
